// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the downstream packet parser.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 234;

  localparam logic [7:0] BYTE_START = 8'd83;
  localparam logic [7:0] BYTE_END   = 8'd69;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage metastability synchroniser; resets to 1 so an idle UART line reads idle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sync <= '1;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// Centre-sampling UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       we,
  output logic       busy,
  output logic       framing_err,
  output logic       parity_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

  logic              w_rx_s;
  logic              r_rx_q;
  logic [FILL_W-1:0] r_fill;
  logic              r_armed;
  state_t            r_state;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_data;
  logic              r_we;
  logic              r_ferr;
`ifdef UART_RX_PARITY_EN
  logic              r_perr;
  logic              r_drop;
`endif

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (w_rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_q    <= 1'b1;
      r_fill    <= '0;
      r_armed   <= 1'b0;
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_drop    <= 1'b0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      r_rx_q <= w_rx_s;
      // The synchroniser's reset value is not a real high; arm only once the line itself reads high.
      if (r_fill != FILL_MAX) r_fill  <= r_fill + 1'b1;
      else if (w_rx_s)        r_armed <= 1'b1;

      case (r_state)
        IDLE: begin
`ifdef UART_RX_PARITY_EN
          r_drop <= 1'b0;
`endif
          if (r_armed && r_rx_q && !w_rx_s) begin
            r_clk_cnt <= '0;
            r_state   <= START;
          end
        end
        START: begin
          if (r_clk_cnt == HALF_CNT) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_bit_idx == 3'd7) r_state <= PARITY;
`else
            if (r_bit_idx == 3'd7) r_state <= STOP;
`endif
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt <= '0;
            r_drop    <= (w_rx_s != ^r_shift);
            r_perr    <= (w_rx_s != ^r_shift);
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (!r_drop) begin
                r_data <= r_shift;
                r_we   <= 1'b1;
              end
`else
              r_data <= r_shift;
              r_we   <= 1'b1;
`endif
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_byte   = r_data;
  assign we          = r_we;
  assign busy        = (r_state != IDLE);
  assign framing_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_perr;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: scoreboard of expected bytes, scenario tasks run in sequence.
module tb_uart_byte_rx;

  localparam int CPB = 234;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_byte;
  logic       we;
  logic       busy;
  logic       framing_err;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic par_flip = 1'b0;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_q[$];

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock       (clk),
    .reset       (reset),
    .rx          (rx),
    .data_byte   (data_byte),
    .we          (we),
    .busy        (busy),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pop expected byte on every we; enforce pulse exclusivity.
  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: got data_byte=%02h, no byte expected", data_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_byte !== e) begin
          n_fail++;
          $display("FAIL we_data: got %02h, expected %02h", data_byte, e);
        end
      end
    end
    if (framing_err) ferr_cnt++;
    if (parity_err)  perr_cnt++;
    if (we || framing_err || parity_err) begin
      n_checks++;
      if ((int'(we) + int'(framing_err) + int'(parity_err)) > 1 || prev_pulse) begin
        n_fail++;
        $display("FAIL pulse_exclusive: we=%b ferr=%b perr=%b prev=%b, expected single isolated pulse",
                 we, framing_err, parity_err, prev_pulse);
      end
    end
    prev_pulse = we | framing_err | parity_err;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_tail(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_flip, CPB);
`endif
    hold(stop, CPB);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, CPB);
    drive_tail(b, stop);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_checks += 5;
    if (data_byte !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", data_byte); end
    if (we !== 1'b0)          begin n_fail++; $display("FAIL reset_we: got %b, expected 0", we); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", framing_err); end
    if (parity_err !== 1'b0)  begin n_fail++; $display("FAIL reset_perr: got %b, expected 0", parity_err); end
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_single;
    int w0;
    w0 = we_cnt;
    exp_q.push_back(8'h53);
    hold(1'b0, CPB);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b, expected 1", busy); end
    drive_tail(8'h53, 1'b1);
    n_checks += 3;
    if (we_cnt - w0 !== 1)     begin n_fail++; $display("FAIL single_we_count: got %0d, expected 1", we_cnt - w0); end
    if (data_byte !== 8'h53)   begin n_fail++; $display("FAIL single_hold: got %02h, expected 53", data_byte); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL single_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int w0, f0;
    logic [7:0] seq [3];
    seq = '{8'h53, 8'h32, 8'h45};
    w0 = we_cnt;
    f0 = ferr_cnt + perr_cnt;
    foreach (seq[i]) exp_q.push_back(seq[i]);
    foreach (seq[i]) drive_frame(seq[i], 1'b1);
    hold(1'b1, CPB);
    n_checks += 3;
    if (we_cnt - w0 !== 3)                begin n_fail++; $display("FAIL b2b_we_count: got %0d, expected 3", we_cnt - w0); end
    if (exp_q.size() !== 0)               begin n_fail++; $display("FAIL b2b_pending: got %0d, expected 0", exp_q.size()); end
    if (ferr_cnt + perr_cnt - f0 !== 0)   begin n_fail++; $display("FAIL b2b_errors: got %0d, expected 0", ferr_cnt + perr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int w0, f0;
    w0 = we_cnt;
    f0 = ferr_cnt + perr_cnt;
    hold(1'b0, 10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b, expected 1", busy); end
    hold(1'b0, 60);
    hold(1'b1, CPB);
    n_checks += 3;
    if (busy !== 1'b0)                  begin n_fail++; $display("FAIL glitch_busy_drop: got %b, expected 0", busy); end
    if (we_cnt - w0 !== 0)              begin n_fail++; $display("FAIL glitch_we: got %0d, expected 0", we_cnt - w0); end
    if (ferr_cnt + perr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_errors: got %0d, expected 0", ferr_cnt + perr_cnt - f0); end
    exp_q.push_back(8'h32);
    drive_frame(8'h32, 1'b1);
    n_checks += 2;
    if (we_cnt - w0 !== 1)   begin n_fail++; $display("FAIL glitch_next_count: got %0d, expected 1", we_cnt - w0); end
    if (data_byte !== 8'h32) begin n_fail++; $display("FAIL glitch_next_data: got %02h, expected 32", data_byte); end
  endtask

  task automatic test_framing;
    int w0, f0;
    w0 = we_cnt;
    f0 = ferr_cnt;
    drive_frame(8'hA5, 1'b0);
    hold(1'b0, 20 * CPB);
    n_checks += 4;
    if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL framing_count: got %0d, expected 1", ferr_cnt - f0); end
    if (we_cnt - w0 !== 0)   begin n_fail++; $display("FAIL framing_we: got %0d, expected 0", we_cnt - w0); end
    if (data_byte !== 8'h32) begin n_fail++; $display("FAIL framing_hold: got %02h, expected 32", data_byte); end
    if (busy !== 1'b1)       begin n_fail++; $display("FAIL framing_busy_break: got %b, expected 1", busy); end
    hold(1'b1, CPB);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_midframe;
    int w0;
    w0 = we_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    reset = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (data_byte !== 8'h00)   begin n_fail++; $display("FAIL midreset_data: got %02h, expected 00", data_byte); end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    hold(1'b1, 6 * CPB);
    n_checks++;
    if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL midreset_aborted_we: got %0d, expected 0", we_cnt - w0); end
    exp_q.push_back(8'h45);
    drive_frame(8'h45, 1'b1);
    n_checks += 2;
    if (we_cnt - w0 !== 1)   begin n_fail++; $display("FAIL midreset_next_count: got %0d, expected 1", we_cnt - w0); end
    if (data_byte !== 8'h45) begin n_fail++; $display("FAIL midreset_next_data: got %02h, expected 45", data_byte); end
  endtask

  task automatic test_held_low;
    int w0;
    w0 = we_cnt;
    reset = 1'b0;
    rx    = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    hold(1'b0, 3 * CPB);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL heldlow_busy: got %b, expected 0", busy); end
    hold(1'b1, CPB);
    exp_q.push_back(8'h53);
    drive_frame(8'h53, 1'b1);
    n_checks++;
    if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL heldlow_we_count: got %0d, expected 1", we_cnt - w0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int w0, p0, f0;
    w0 = we_cnt;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    par_flip = 1'b0;
    exp_q.push_back(8'h53);
    drive_frame(8'h53, 1'b1);
    hold(1'b1, CPB);
    n_checks += 2;
    if (we_cnt - w0 !== 1)   begin n_fail++; $display("FAIL parity_ok_we: got %0d, expected 1", we_cnt - w0); end
    if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL parity_ok_err: got %0d, expected 0", perr_cnt - p0); end
    par_flip = 1'b1;
    drive_frame(8'h53, 1'b1);
    par_flip = 1'b0;
    hold(1'b1, CPB);
    n_checks += 3;
    if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL parity_bad_err: got %0d, expected 1", perr_cnt - p0); end
    if (we_cnt - w0 !== 1)   begin n_fail++; $display("FAIL parity_bad_we: got %0d, expected 1", we_cnt - w0); end
    if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL parity_bad_ferr: got %0d, expected 0", ferr_cnt - f0); end
  endtask
`else
  task automatic test_parity;
    n_checks++;
    if (perr_cnt !== 0) begin n_fail++; $display("FAIL parity_tied: got %0d pulses, expected 0", perr_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_midframe;
    test_held_low;
    test_parity;
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_pending: got %0d, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
